sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port request arbiter sitting between the DMA engine's requesters (port 0, port 1) and a single-port synchronous SRAM macro (active-low chip-select/write-enable, one-cycle registered read data). Fair round-robin arbitration gives each requester a valid/ready command channel. Each requester also gets a one-deep buffered read-response channel with backpressure. Out-of-range addresses are trapped here, so the SRAM never sees an illegal index.

## Interface
- DATA_WIDTH, 32, SRAM word width
- ADDR_WIDTH, 9, address width (ceil(log2(DEPTH)))
- DEPTH, 512, number of valid SRAM words; legal addresses 0..DEPTH-1
- inst_clk  in  1  clock, all logic on rising edge
- inst_rst_n  in  1  asynchronous, active-low reset
- pN_req_valid  in  1  port N (N=0,1) command valid
- pN_req_ready  out  1  port N command accepted when valid&ready at rising edge
- pN_req_we  in  1  1=write, 0=read
- pN_req_addr  in  ADDR_WIDTH  word address
- pN_req_wdata  in  DATA_WIDTH  write data
- pN_rsp_valid  out  1  read response valid
- pN_rsp_ready  in  1  response consumed when valid&ready at rising edge
- pN_rsp_rdata  out  DATA_WIDTH  read data
- pN_rsp_err  out  1  1 = address was >= DEPTH
- sram_cs_n  out  1  SRAM chip select, active low
- sram_wr_n  out  1  SRAM write enable, active low (high = read)
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM registered read data

## Operation
- Eligibility: port N is eligible when pN_req_valid=1 and port N is not blocked. Port N is blocked while it has a read in flight or its response buffer is full.
- Grant rules:
  - At most one grant per cycle, computed combinationally from eligibility and the last_grant pointer.
  - One eligible port: it is granted.
  - Both eligible: the port != last_grant is granted.
  - last_grant updates only on a grant. Reset value 1, so port 0 wins the first tie.
- pN_req_ready = grant_N. It is never asserted for an ineligible port.
- SRAM command, driven combinationally in the grant cycle:
  - sram_cs_n=0, sram_wr_n=~req_we, sram_addr=req_addr, sram_wdata=req_wdata.
  - With no grant: sram_cs_n=1, sram_wr_n=1, addr/wdata=0.
- Out-of-range (addr >= DEPTH):
  - The request is still accepted (ready=1), but sram_cs_n stays 1.
  - Write: silently dropped.
  - Read: response with rsp_err=1, rdata=0, same latency as a legal read.
- Writes produce no response.
- Per-port read tracker:
  - States: IDLE -> INFLIGHT (read accepted) -> HOLD (data captured into buffer) -> IDLE (rsp valid&ready).
  - INFLIGHT lasts exactly one cycle. In it, sram_rdata (or 0/err for out-of-range) is captured into the port's buffer at the rising edge.
  - HOLD keeps rsp_valid=1 with stable rdata/err until rsp_ready=1.
  - Port blocked in INFLIGHT and HOLD, so at most one outstanding read per port.
- Independence: the two ports' trackers are independent. Port 1 may be granted while port 0 is INFLIGHT or HOLD.

## Timing
- Reset (async assert, sync release): all outputs 0 except sram_cs_n=1 and sram_wr_n=1. Both trackers IDLE, last_grant=1.
- Read latency: accept at edge T; data captured at edge T+1; pN_rsp_valid=1 in the cycle after edge T+1. Earliest consumption is edge T+2.
- Next read, same port: rsp consumed at edge R; port eligible again in the cycle after R. Back-to-back reads from one port occur every 3 cycles minimum.
- Throughput: SRAM can be issued a command every cycle when ports alternate, or when the requester issues writes.
- Back-to-back reads from different ports in consecutive cycles are required to work. Capture at edge T+1 uses the SRAM output from the edge-T read, before it is overwritten.
- Reset mid-operation: in-flight reads and held responses are discarded; no response is emitted after reset release.

## Test plan
- Reset: assert inst_rst_n=0 with both ports driving valid -> sram_cs_n=1, all ready/rsp_valid=0, rdata=0.
- Write then read: p0 writes 0xDEADBEEF @0x005, then reads @0x005 -> p0_rsp_valid=1 two edges after read accept, rdata=0xDEADBEEF, err=0.
- Contention: both ports request a read every cycle for 8 cycles -> grants alternate 0,1,0,1 after the first tie goes to port 0. Each port's ready is low while its tracker is non-IDLE.
- Backpressure: p1 read @0x010 holding 0x12345678, p1_rsp_ready=0 for 5 cycles -> rsp_valid and rdata held stable. p1_req_ready stays 0 and p1 gets no further grants until consumption.
- Out-of-range: p0 write @DEPTH (512 with ADDR_WIDTH=10) -> sram_cs_n stays 1. p0 read @600 -> rsp_err=1, rdata=0, same latency as a legal read.
- Reset during INFLIGHT: p0 read accepted, inst_rst_n pulsed low next cycle -> no p0_rsp_valid afterward, and p0 is accepted again immediately after release.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous SRAM.
// Each port owns a one-deep read-response buffer; out-of-range addresses never reach the SRAM.

module sram_arbiter_port #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  inst_clk,
    input  logic                  inst_rst_n,
    input  logic                  rd_accept,
    input  logic                  rd_oob,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    input  logic                  rsp_ready,
    output logic                  blocked,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    typedef enum logic [1:0] {IDLE, INFLIGHT, HOLD} state_t;

    state_t state;
    logic   oob_q;

    always_ff @(posedge inst_clk or negedge inst_rst_n) begin
        if (!inst_rst_n) begin
            state     <= IDLE;
            oob_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_accept) begin
                        state <= INFLIGHT;
                        oob_q <= rd_oob;
                    end
                end
                // SRAM output still holds the word read at the accept edge
                INFLIGHT: begin
                    state     <= HOLD;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= oob_q ? '0 : sram_rdata;
                    rsp_err   <= oob_q;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign blocked = (state != IDLE);
endmodule

module sram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512
) (
    input  logic                  inst_clk,
    input  logic                  inst_rst_n,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    input  logic                  p0_rsp_ready,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    output logic                  p0_rsp_err,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    input  logic                  p1_rsp_ready,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  p1_rsp_err,
    output logic                  sram_cs_n,
    output logic                  sram_wr_n,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);
    localparam int NUM_PORTS = 2;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    logic [NUM_PORTS-1:0]                 req_valid, req_we, rsp_ready;
    logic [NUM_PORTS-1:0]                 oob, blocked, elig, grant;
    logic [NUM_PORTS-1:0]                 rsp_valid, rsp_err;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata, rsp_rdata;
    logic                                 last_grant;
    logic                                 sel;

    assign req_valid = {p1_req_valid, p0_req_valid};
    assign req_we    = {p1_req_we,    p0_req_we};
    assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};
    assign req_addr  = {p1_req_addr,  p0_req_addr};
    assign req_wdata = {p1_req_wdata, p0_req_wdata};

    generate
        for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
            assign oob[n] = {1'b0, req_addr[n]} >= DEPTH_L;

            sram_arbiter_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
                .inst_clk   (inst_clk),
                .inst_rst_n (inst_rst_n),
                .rd_accept  (grant[n] & ~req_we[n]),
                .rd_oob     (oob[n]),
                .sram_rdata (sram_rdata),
                .rsp_ready  (rsp_ready[n]),
                .blocked    (blocked[n]),
                .rsp_valid  (rsp_valid[n]),
                .rsp_rdata  (rsp_rdata[n]),
                .rsp_err    (rsp_err[n])
            );
        end
    endgenerate

    // Reset gates eligibility so nothing is granted while inst_rst_n is held low
    assign elig     = req_valid & ~blocked & {NUM_PORTS{inst_rst_n}};
    assign grant[0] = elig[0] & (~elig[1] | last_grant);
    assign grant[1] = elig[1] & (~elig[0] | ~last_grant);
    assign sel      = grant[1];

    always_ff @(posedge inst_clk or negedge inst_rst_n) begin
        if (!inst_rst_n)
            last_grant <= 1'b1;
        else if (|grant)
            last_grant <= grant[1];
    end

    always_comb begin
        sram_cs_n  = 1'b1;
        sram_wr_n  = 1'b1;
        sram_addr  = '0;
        sram_wdata = '0;
        if ((|grant) && !oob[sel]) begin
            sram_cs_n  = 1'b0;
            sram_wr_n  = ~req_we[sel];
            sram_addr  = req_addr[sel];
            sram_wdata = req_wdata[sel];
        end
    end

    assign p0_req_ready = grant[0];
    assign p1_req_ready = grant[1];
    assign p0_rsp_valid = rsp_valid[0];
    assign p1_rsp_valid = rsp_valid[1];
    assign p0_rsp_rdata = rsp_rdata[0];
    assign p1_rsp_rdata = rsp_rdata[1];
    assign p0_rsp_err   = rsp_err[0];
    assign p1_rsp_err   = rsp_err[1];
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: bench-side SRAM, request-level reference model checked
// every cycle, plus hand-computed literal checks for each scenario.

module tb_sram_arbiter;
    localparam int DW = 32, AW = 10, DEPTH = 512;

    logic inst_clk = 1'b0;
    logic inst_rst_n;
    always #5 inst_clk = ~inst_clk;

    logic [1:0]         req_valid, req_we, rsp_ready;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][DW-1:0] req_wdata;

    logic p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
    logic [DW-1:0] p0_rsp_rdata, p1_rsp_rdata;
    logic sram_cs_n, sram_wr_n;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    logic [1:0]         req_ready, rsp_valid, rsp_err;
    logic [1:0][DW-1:0] rsp_rdata;
    assign req_ready = {p1_req_ready, p0_req_ready};
    assign rsp_valid = {p1_rsp_valid, p0_rsp_valid};
    assign rsp_err   = {p1_rsp_err,   p0_rsp_err};
    assign rsp_rdata = {p1_rsp_rdata, p0_rsp_rdata};

    sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .inst_clk(inst_clk), .inst_rst_n(inst_rst_n),
        .p0_req_valid(req_valid[0]), .p0_req_ready(p0_req_ready), .p0_req_we(req_we[0]),
        .p0_req_addr(req_addr[0]), .p0_req_wdata(req_wdata[0]),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(rsp_ready[0]),
        .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(req_valid[1]), .p1_req_ready(p1_req_ready), .p1_req_we(req_we[1]),
        .p1_req_addr(req_addr[1]), .p1_req_wdata(req_wdata[1]),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(rsp_ready[1]),
        .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
        .sram_cs_n(sram_cs_n), .sram_wr_n(sram_wr_n), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Bench SRAM macro: one-cycle registered read data
    logic [DW-1:0] sram_mem [1 << AW];
    logic [DW-1:0] model_mem [DEPTH];

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'hA500_0000 ^ (i * 32'h0001_0203);
    endfunction

    initial begin
        sram_rdata = '0;
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = init_val(i);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = init_val(i);
    end

    always @(posedge inst_clk) begin
        if (!sram_cs_n) begin
            if (!sram_wr_n) sram_mem[sram_addr] <= sram_wdata;
            else            sram_rdata <= sram_mem[sram_addr];
        end
    end

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per port, whether a read is owed, cycles until it shows, and its payload
    logic [1:0]    m_pend, m_err;
    int            m_wait [2];
    logic [DW-1:0] m_data [2];
    logic          m_last;

    always @(negedge inst_clk) begin : cmp
        logic [1:0] e, g;
        int         s;
        logic       xv, legal;
        if (!inst_rst_n) begin
            chk("rst_req_ready", req_ready, 2'b00);
            chk("rst_rsp_valid", rsp_valid, 2'b00);
            chk("rst_rsp_err",   rsp_err,   2'b00);
            chk("rst_p0_rdata",  p0_rsp_rdata, 0);
            chk("rst_p1_rdata",  p1_rsp_rdata, 0);
            chk("rst_cs_n",  sram_cs_n, 1);
            chk("rst_wr_n",  sram_wr_n, 1);
            chk("rst_addr",  sram_addr, 0);
            chk("rst_wdata", sram_wdata, 0);
            m_pend = 2'b00;
            m_last = 1'b1;
        end else begin
            e    = req_valid & ~m_pend;
            g[0] = e[0] && (!e[1] || m_last);
            g[1] = e[1] && (!e[0] || !m_last);
            s     = g[1] ? 1 : 0;
            legal = req_addr[s] < DEPTH;
            chk("req_ready", req_ready, g);
            if (g != 2'b00 && legal) begin
                chk("sram_cs_n",  sram_cs_n, 0);
                chk("sram_wr_n",  sram_wr_n, !req_we[s]);
                chk("sram_addr",  sram_addr, req_addr[s]);
                chk("sram_wdata", sram_wdata, req_wdata[s]);
            end else if (g != 2'b00) begin
                chk("oob_cs_n", sram_cs_n, 1);
            end else begin
                chk("idle_cs_n", sram_cs_n, 1);
                chk("idle_wr_n", sram_wr_n, 1);
                chk("idle_addr", sram_addr, 0);
                chk("idle_wdata", sram_wdata, 0);
            end
            for (int p = 0; p < 2; p++) begin
                xv = m_pend[p] && (m_wait[p] == 0);
                chk($sformatf("p%0d_rsp_valid", p), rsp_valid[p], xv);
                if (xv) begin
                    chk($sformatf("p%0d_rsp_rdata", p), rsp_rdata[p], m_data[p]);
                    chk($sformatf("p%0d_rsp_err", p), rsp_err[p], m_err[p]);
                end
                if (xv && rsp_ready[p]) m_pend[p] = 1'b0;
                else if (m_pend[p] && m_wait[p] > 0) m_wait[p]--;
            end
            if (g != 2'b00) begin
                m_last = g[1];
                if (req_we[s]) begin
                    if (legal) model_mem[req_addr[s]] = req_wdata[s];
                end else begin
                    m_pend[s] = 1'b1;
                    m_wait[s] = 1;
                    m_data[s] = legal ? model_mem[req_addr[s]] : '0;
                    m_err[s]  = !legal;
                end
            end
        end
    end

    // Present a request on port p, hold until accepted; returns just after the accept edge
    task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output logic cs_seen);
        logic ok;
        int   n;
        req_valid[p] = 1'b1; req_we[p] = we; req_addr[p] = a; req_wdata[p] = d;
        n = 0; ok = 1'b0; cs_seen = 1'b1;
        do begin
            @(negedge inst_clk);
            ok = req_ready[p];
            cs_seen = sram_cs_n;
            @(posedge inst_clk); #1;
            n++;
        end while (!ok && n < 20);
        chk($sformatf("p%0d_issue_accepted", p), ok, 1);
        req_valid[p] = 1'b0;
    endtask

    task automatic step();
        @(posedge inst_clk); #1;
    endtask

    logic [7:0] pat0, pat1;
    logic       cs;

    initial begin
        inst_rst_n = 1'b0;
        req_valid = 2'b11; req_we = 2'b00; rsp_ready = 2'b11;
        req_addr[0] = 10'h020; req_addr[1] = 10'h021;
        req_wdata[0] = '0; req_wdata[1] = '0;

        // Reset with both ports requesting
        repeat (2) @(posedge inst_clk);
        @(negedge inst_clk);
        chk("lit_rst_cs_n", sram_cs_n, 1);
        chk("lit_rst_ready", req_ready, 2'b00);
        chk("lit_rst_rsp_valid", rsp_valid, 2'b00);
        step();
        inst_rst_n = 1'b1;

        // Contention: reads every cycle from both; ready sequence is p0,p1,-,p0,p1,-,p0,p1
        pat0 = 8'b0100_1001;
        pat1 = 8'b1001_0010;
        for (int i = 0; i < 8; i++) begin
            @(negedge inst_clk);
            chk($sformatf("lit_cont_p0_ready[%0d]", i), p0_req_ready, pat0[i]);
            chk($sformatf("lit_cont_p1_ready[%0d]", i), p1_req_ready, pat1[i]);
            step();
        end
        req_valid = 2'b00;
        repeat (4) step();

        // Write streams from both ports alternate every cycle
        for (int i = 0; i < 6; i++) begin
            req_valid = 2'b11; req_we = 2'b11;
            req_addr[0] = AW'(10'h100 + i); req_addr[1] = AW'(10'h180 + i);
            req_wdata[0] = 32'h1000_0000 + i; req_wdata[1] = 32'h2000_0000 + i;
            @(negedge inst_clk);
            chk($sformatf("lit_wr_alt[%0d]", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
        end
        req_valid = 2'b00; req_we = 2'b00;
        step();

        // Write then read back on port 0
        issue(0, 1'b1, 10'h005, 32'hDEAD_BEEF, cs);
        issue(0, 1'b0, 10'h005, '0, cs);
        @(negedge inst_clk);
        chk("lit_rd_inflight_valid", p0_rsp_valid, 0);
        step();
        @(negedge inst_clk);
        chk("lit_rd_valid", p0_rsp_valid, 1);
        chk("lit_rd_rdata", p0_rsp_rdata, 32'hDEAD_BEEF);
        chk("lit_rd_err", p0_rsp_err, 0);
        repeat (2) step();

        // Backpressure on port 1 with a second read queued behind it
        rsp_ready[1] = 1'b0;
        issue(1, 1'b1, 10'h010, 32'h1234_5678, cs);
        issue(1, 1'b0, 10'h010, '0, cs);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 10'h011;
        @(negedge inst_clk);
        chk("lit_bp_inflight_ready", p1_req_ready, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge inst_clk);
            chk($sformatf("lit_bp_valid[%0d]", i), p1_rsp_valid, 1);
            chk($sformatf("lit_bp_rdata[%0d]", i), p1_rsp_rdata, 32'h1234_5678);
            chk($sformatf("lit_bp_ready[%0d]", i), p1_req_ready, 0);
        end
        step();
        rsp_ready[1] = 1'b1;
        @(negedge inst_clk);
        chk("lit_bp_hold_ready", p1_req_ready, 0);
        step();
        @(negedge inst_clk);
        chk("lit_bp_reaccept", p1_req_ready, 1);
        step();
        req_valid[1] = 1'b0;
        repeat (4) step();

        // Out-of-range write and read
        issue(0, 1'b1, 10'd512, 32'hBAD0_BAD0, cs);
        chk("lit_oob_wr_cs_n", cs, 1);
        issue(0, 1'b0, 10'd600, '0, cs);
        chk("lit_oob_rd_cs_n", cs, 1);
        @(negedge inst_clk);
        chk("lit_oob_inflight_valid", p0_rsp_valid, 0);
        step();
        @(negedge inst_clk);
        chk("lit_oob_valid", p0_rsp_valid, 1);
        chk("lit_oob_err", p0_rsp_err, 1);
        chk("lit_oob_rdata", p0_rsp_rdata, 0);
        repeat (2) step();

        // Reset while a port-0 read is in flight
        issue(0, 1'b0, 10'h005, '0, cs);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 10'h005;
        inst_rst_n = 1'b0;
        @(negedge inst_clk);
        chk("lit_mrst_valid", p0_rsp_valid, 0);
        step();
        inst_rst_n = 1'b1;
        @(negedge inst_clk);
        chk("lit_mrst_reaccept", p0_req_ready, 1);
        chk("lit_mrst_valid_rel", p0_rsp_valid, 0);
        step();
        req_valid[0] = 1'b0;
        @(negedge inst_clk);
        chk("lit_mrst_valid_rel1", p0_rsp_valid, 0);
        step();
        @(negedge inst_clk);
        chk("lit_mrst_new_valid", p0_rsp_valid, 1);
        chk("lit_mrst_new_rdata", p0_rsp_rdata, 32'hDEAD_BEEF);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
